// File: rtl/control_rx_if.sv
// -----------------------------------------------------------------------------
// control_rx_if
// Host-side handshake of the UART receive controller.
//   o_data   received word, bit 0 = first data bit on the line
//   o_valid  o_data holds a word the host has not consumed yet
//   i_ack    host consumes o_data while o_valid = 1
// Modports:
//   master   the receiver (drives o_data / o_valid, samples i_ack)
//   slave    the host     (samples o_data / o_valid, drives i_ack)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface control_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ack;

  modport master (output o_data, output o_valid, input i_ack);
  modport slave  (input o_data, input o_valid, output i_ack);
endinterface

// File: rtl/control_rx.sv
// -----------------------------------------------------------------------------
// control_rx
// UART receive controller: synchronises the serial line, validates the start
// bit at mid-bit, deserialises LSB-first data, checks the stop bit (and even
// parity when built with UART_RX_PARITY_EN) and hands each word to the host
// over a valid/ack handshake.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-low reset
//   i_rx           asynchronous serial line, idles high
//   i_sample_tick  one-cycle enable at OVERSAMPLE x baud rate
//   host           control_rx_if.master: o_data / o_valid / i_ack
//   o_busy         a frame is in progress (state other than IDLE)
//   o_frame_err    1-clock pulse: stop bit sampled low
//   o_parity_err   1-clock pulse: parity mismatch (0 without the macro)
//   o_overrun      1-clock pulse: good frame dropped, o_valid still set
//
// Build option
//   UART_RX_PARITY_EN  adds the even-parity bit between data and stop.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module control_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx,
  input  logic                i_sample_tick,
  control_rx_if.master        host,
  output logic                o_busy,
  output logic                o_frame_err,
  output logic                o_parity_err,
  output logic                o_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_meta_q;
  logic                 rx_q;
  logic                 rx;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  // NOTE: sequential state is always written with <=, so every flop samples
  // the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_q      <= rx_meta_q;
    end
  end

  assign rx = rx_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;     // parity verdict, acted on at the stop sample
  logic parity_err_q;
`endif

  // NOTE: the shift register is plain flops, not a memory, so it is cleared
  // in reset along with everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Pulses default low; a later assignment in this block wins.
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Host consumption acts on every clock; a completion below overrides.
      if (valid_q && host.i_ack) valid_q <= 1'b0;

      if (i_sample_tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
            end
          end

          S_START: begin
            if (tick_cnt_q == TICK_MID) begin
              if (!rx) begin
                state_q    <= S_DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= S_IDLE;       // glitch, silently ignored
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          S_DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              shift_q    <= {rx, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              // Even parity: data bits plus parity bit must XOR to zero.
              par_bad_q  <= (^shift_q) ^ rx;
              tick_cnt_q <= '0;
              state_q    <= S_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif

          S_STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (!rx) begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad_q) begin
                parity_err_q <= 1'b1;
                state_q      <= S_IDLE;
`endif
              end else begin
                state_q <= S_IDLE;
                if (!valid_q || host.i_ack) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          // Held-low line: wait for it to return high so one break gives
          // exactly one frame error.
          S_BREAK: begin
            if (rx) state_q <= S_IDLE;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign host.o_data  = data_q;
  assign host.o_valid = valid_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
